// File: rtl/data_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_arb_pkg
// Shared types and constants for the core data-bus arbiter.
//   dbus_req_t   : request fields presented by one requester (addr/we/be/wdata)
//   dbus_rsp_t   : response fields returned from memory (rdata/err)
//   DBUS_LSU_IDX : requester index of the execute-stage load/store unit
//   ARB_*        : arbiter FSM state encodings
// -----------------------------------------------------------------------------
package data_bus_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dbus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dbus_rsp_t;

    localparam int DBUS_LSU_IDX = 0;

    // Arbiter FSM states
    localparam logic [0:0] ARB_IDLE   = 1'b0;  // nothing held, arbitrate freely
    localparam logic [0:0] ARB_LOCKED = 1'b1;  // sel_q presented, awaiting grant

endpackage

// File: rtl/data_bus_arb_owner_fifo.sv
// -----------------------------------------------------------------------------
// arb_owner_fifo
// In-order FIFO of requester ids, one entry per accepted-but-unanswered
// transaction. The head is the owner of the next response to arrive.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i, id_i : enqueue id_i (taken when not full, or when popping this cycle)
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : id at the head of the queue
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   count_o      : number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module arb_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [ID_W-1:0]          id_i,
    input  logic                     pop_i,
    output logic [ID_W-1:0]          head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [ID_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    assign do_pop  = pop_i && !empty_o;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = id_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/data_bus_arb.sv
// -----------------------------------------------------------------------------
// data_bus_arb
// Round-robin arbiter sharing the core data-memory port between NR_REQ
// requesters (index 0 = load/store unit, index 1 = debug/system-bus unit).
// A request presented but not yet granted is locked to its requester until
// granted or withdrawn. Accepted transactions are recorded in an owner FIFO so
// responses are routed back to their issuer in order.
//
// Handshake: a transfer happens in a cycle where data_req_o && data_gnt_i; the
// upstream m_gnt_o mirrors that cycle for the selected requester only. A
// response is one cycle of data_rvalid_i and is forwarded in the same cycle to
// the FIFO head as m_rvalid_o, with rdata/err qualified by it.
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   m_req_i/addr/we/be/wdata : per-requester request fields (flattened vectors)
//   m_gnt_o, m_rvalid_o   : per-requester grant / response valid (one-hot or 0)
//   m_rdata_o, m_err_o    : broadcast response data/error
//   data_*                : downstream memory port
//   outst_cnt_o           : in-flight transaction count
//   proto_err_o           : sticky, response seen with nothing in flight
// -----------------------------------------------------------------------------
module data_bus_arb
    import data_bus_arb_pkg::*;
#(
    parameter int NR_REQ    = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NR_REQ-1:0]            m_req_i,
    input  logic [NR_REQ*32-1:0]         m_addr_i,
    input  logic [NR_REQ-1:0]            m_we_i,
    input  logic [NR_REQ*4-1:0]          m_be_i,
    input  logic [NR_REQ*32-1:0]         m_wdata_i,
    output logic [NR_REQ-1:0]            m_gnt_o,
    output logic [NR_REQ-1:0]            m_rvalid_o,
    output logic [31:0]                  m_rdata_o,
    output logic                         m_err_o,
    output logic                         data_req_o,
    input  logic                         data_gnt_i,
    output logic [31:0]                  data_addr_o,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [31:0]                  data_wdata_o,
    input  logic                         data_rvalid_i,
    input  logic [31:0]                  data_rdata_i,
    input  logic                         data_err_i,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt_o,
    output logic                         proto_err_o
);

    localparam int SEL_W = $clog2(NR_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             proto_err_q, proto_err_d;

    dbus_req_t        m_req_s [NR_REQ];
    dbus_req_t        sel_req;
    dbus_rsp_t        rsp;

    logic [SEL_W-1:0] rr_sel;
    logic             rr_hit;
    logic [SEL_W-1:0] cur_sel;
    logic             req_valid;
    logic             accept;
    logic             eligible;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SEL_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_cnt;

    // Unpack the flattened per-requester vectors into request structs.
    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            m_req_s[i].addr  = m_addr_i[i*32 +: 32];
            m_req_s[i].we    = m_we_i[i];
            m_req_s[i].be    = m_be_i[i*4 +: 4];
            m_req_s[i].wdata = m_wdata_i[i*32 +: 32];
        end
    end

    assign fifo_pop = data_rvalid_i && !fifo_empty;
    // A full owner FIFO blocks new requests unless its head retires this cycle.
    assign eligible = !fifo_full || fifo_pop;

    // First active request at or after rr_ptr_q, searching cyclically.
    always_comb begin
        rr_sel = rr_ptr_q;
        rr_hit = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NR_REQ) begin
                idx = idx - NR_REQ;
            end
            if (!rr_hit && m_req_i[idx]) begin
                rr_hit = 1'b1;
                rr_sel = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        cur_sel   = sel_q;
        req_valid = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (eligible && rr_hit) begin
                    cur_sel   = rr_sel;
                    req_valid = 1'b1;
                end
            end
            ARB_LOCKED: begin
                // Only the locked requester is considered; withdrawing its
                // request abandons the attempt without pushing anything.
                if (!m_req_i[sel_q]) begin
                    state_d = ARB_IDLE;
                end else if (eligible) begin
                    req_valid = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Keep every output quiet while reset is held, even with requests up.
        if (rst_i) begin
            req_valid = 1'b0;
        end

        accept = req_valid && data_gnt_i;

        if (req_valid && !data_gnt_i) begin
            state_d = ARB_LOCKED;
            sel_d   = cur_sel;
        end
        if (accept) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (cur_sel == SEL_W'(NR_REQ - 1)) ? '0 : cur_sel + 1'b1;
        end

        proto_err_d = proto_err_q | (data_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= SEL_W'(DBUS_LSU_IDX);
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTST),
        .ID_W  (SEL_W)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .id_i    (cur_sel),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Downstream request fields, zero when no request is presented.
    always_comb begin
        sel_req = m_req_s[cur_sel];
        if (!req_valid) begin
            sel_req = '0;
        end
    end

    assign data_req_o   = req_valid;
    assign data_addr_o  = sel_req.addr;
    assign data_we_o    = sel_req.we;
    assign data_be_o    = sel_req.be;
    assign data_wdata_o = sel_req.wdata;

    // Response pass-through, qualified by an actual pop.
    always_comb begin
        rsp = '0;
        if (fifo_pop) begin
            rsp.rdata = data_rdata_i;
            rsp.err   = data_err_i;
        end
    end

    assign m_rdata_o = rsp.rdata;
    assign m_err_o   = rsp.err;

    always_comb begin
        for (int i = 0; i < NR_REQ; i++) begin
            m_gnt_o[i]    = accept && (cur_sel == SEL_W'(i));
            m_rvalid_o[i] = fifo_pop && (fifo_head == SEL_W'(i));
        end
    end

    assign outst_cnt_o = fifo_cnt;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_data_bus_arb.sv
module tb_data_bus_arb;

  localparam int NR = 2;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   m_req;
  logic [NR*32-1:0] m_addr;
  logic [NR-1:0]   m_we;
  logic [NR*4-1:0] m_be;
  logic [NR*32-1:0] m_wdata;
  logic [NR-1:0]   m_gnt;
  logic [NR-1:0]   m_rvalid;
  logic [31:0]     m_rdata;
  logic            m_err;
  logic            data_req;
  logic            data_gnt;
  logic [31:0]     data_addr;
  logic            data_we;
  logic [3:0]      data_be;
  logic [31:0]     data_wdata;
  logic            data_rvalid;
  logic [31:0]     data_rdata;
  logic            data_err;
  logic [$clog2(MO):0] outst_cnt;
  logic            proto_err;

  data_bus_arb #(.NR_REQ(NR), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
    .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
    .outst_cnt_o(outst_cnt), .proto_err_o(proto_err)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: who owns each in-flight transaction, whose request is
  // being held waiting for a grant, and whose turn it is
  int own_q[$];
  int rr_m    = 0;
  bit held_m  = 0;
  int held_id = 0;
  bit perr_m  = 0;

  // check combinational outputs for the current inputs, then clock once
  task automatic cycle();
    int cand;
    bit present;
    bit pop_m;
    bit room;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_rv;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic e_we, e_err;
    logic [3:0] e_be;
    #1;
    cand = 0;
    present = 0;
    pop_m = 0;
    room = 0;
    if (!rst) begin
      pop_m = data_rvalid && (own_q.size() > 0);
      room  = (own_q.size() < MO) || pop_m;
      if (held_m) begin
        cand = held_id;
        present = m_req[cand] && room;
      end else if (room) begin
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (rr_m + k) % NR;
          if (!present && m_req[idx]) begin
            present = 1;
            cand = idx;
          end
        end
      end
    end
    e_addr  = present ? m_addr[cand*32 +: 32] : 32'h0;
    e_wdata = present ? m_wdata[cand*32 +: 32] : 32'h0;
    e_we    = present ? m_we[cand] : 1'b0;
    e_be    = present ? m_be[cand*4 +: 4] : 4'h0;
    e_gnt   = (present && data_gnt) ? NR'(1 << cand) : '0;
    e_rv    = pop_m ? NR'(1 << own_q[0]) : '0;
    e_rdata = pop_m ? data_rdata : 32'h0;
    e_err   = pop_m ? data_err : 1'b0;

    chk("data_req", 32'(data_req), 32'(present));
    chk("data_addr", data_addr, e_addr);
    chk("data_we", 32'(data_we), 32'(e_we));
    chk("data_be", 32'(data_be), 32'(e_be));
    chk("data_wdata", data_wdata, e_wdata);
    chk("m_gnt", 32'(m_gnt), 32'(e_gnt));
    chk("m_rvalid", 32'(m_rvalid), 32'(e_rv));
    chk("m_rdata", m_rdata, e_rdata);
    chk("m_err", 32'(m_err), 32'(e_err));
    chk("outst_cnt", 32'(outst_cnt), rst ? 32'd0 : 32'(own_q.size()));
    chk("proto_err", 32'(proto_err), rst ? 32'd0 : 32'(perr_m));

    @(posedge clk);
    #1;
    if (rst) begin
      own_q.delete();
      rr_m = 0;
      held_m = 0;
      held_id = 0;
      perr_m = 0;
    end else begin
      if (data_rvalid && own_q.size() == 0) perr_m = 1;
      if (pop_m) void'(own_q.pop_front());
      if (held_m && !m_req[held_id]) begin
        held_m = 0;
      end else if (present && data_gnt) begin
        own_q.push_back(cand);
        rr_m = (cand + 1) % NR;
        held_m = 0;
      end else if (present) begin
        held_m = 1;
        held_id = cand;
      end
    end
  endtask

  // driver: apply one cycle of inputs, then check and clock
  task automatic drv(input logic [NR-1:0] rq, input bit g, input bit rv,
                     input logic [31:0] rd, input bit er, input bit rs);
    m_req       = rq;
    data_gnt    = g;
    data_rvalid = rv;
    data_rdata  = rd;
    data_err    = er;
    rst         = rs;
    cycle();
  endtask

  task automatic do_reset();
    drv('0, 0, 0, 32'h0, 0, 1);
    drv('0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    m_req = '0;
    m_addr = {32'h0000_0100, 32'h0000_0040};
    m_we = 2'b10;
    m_be = {4'hC, 4'hF};
    m_wdata = {32'hB1B1_0001, 32'hA0A0_0000};
    data_gnt = 0;
    data_rvalid = 0;
    data_rdata = 0;
    data_err = 0;
    @(posedge clk);
    #1;
    do_reset();

    // single LSU load, response two cycles later
    drv(2'b01, 1, 0, 32'h0, 0, 0);
    drv(2'b00, 1, 0, 32'h0, 0, 0);
    drv(2'b00, 1, 1, 32'hDEADBEEF, 0, 0);
    drv(2'b00, 1, 0, 32'h0, 0, 0);

    // both requesting, alternating grants, responses in order
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drv(2'b11, 1, (k > 0), 32'h5000_0000 + 32'(k), 0, 0);
    end
    drv(2'b00, 1, 1, 32'h5000_00FF, 0, 0);

    // requester 1 locked while grant withheld; requester 0 waits
    do_reset();
    drv(2'b10, 0, 0, 32'h0, 0, 0);
    drv(2'b11, 0, 0, 32'h0, 0, 0);
    drv(2'b11, 0, 0, 32'h0, 0, 0);
    drv(2'b11, 1, 0, 32'h0, 0, 0);
    drv(2'b01, 1, 0, 32'h0, 0, 0);
    drv(2'b00, 0, 1, 32'h1111_1111, 0, 0);
    drv(2'b00, 0, 1, 32'h2222_2222, 0, 0);

    // owner FIFO full; same-cycle pop admits the next request
    do_reset();
    drv(2'b01, 1, 0, 32'h0, 0, 0);
    drv(2'b10, 1, 0, 32'h0, 0, 0);
    drv(2'b01, 1, 0, 32'h0, 0, 0);
    drv(2'b01, 1, 1, 32'h3333_3333, 0, 0);
    drv(2'b00, 1, 1, 32'h4444_4444, 0, 0);
    drv(2'b00, 1, 1, 32'h5555_5555, 0, 0);

    // error response for requester 1
    do_reset();
    drv(2'b10, 1, 0, 32'h0, 0, 0);
    drv(2'b00, 1, 1, 32'h0000_1234, 1, 0);

    // stray response, then reset while locked
    do_reset();
    drv(2'b00, 0, 1, 32'h6666_6666, 0, 0);
    drv(2'b00, 0, 0, 32'h0, 0, 0);
    drv(2'b00, 0, 0, 32'h0, 0, 0);
    drv(2'b01, 0, 0, 32'h0, 0, 0);
    drv(2'b01, 0, 0, 32'h0, 0, 1);
    drv(2'b01, 0, 0, 32'h0, 0, 0);
    drv(2'b00, 1, 1, 32'h0, 0, 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      m_addr  = {$urandom(), $urandom()};
      m_wdata = {$urandom(), $urandom()};
      m_we    = NR'($urandom_range(0, 3));
      m_be    = 8'($urandom_range(0, 255));
      drv(NR'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0),
          $urandom(),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
